// File: rtl/issue_pair.sv
// Dual-issue pairing stage: splits a fetched instruction pair into one or two issue lanes, serialising RAW/WAW-dependent pairs.
// Optional split counter output enabled by defining ISSUE_PAIR_SPLIT_CNT_EN.
module issue_pair #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_instr0,
  input  logic [XLEN-1:0]    in_instr1,
  input  logic               out_ready,
  output logic               issue_valid_1,
  output logic               issue_valid_2,
  output logic [XLEN-1:0]    issue_instr_1,
  output logic [XLEN-1:0]    issue_instr_2,
  output logic [XLEN-1:0]    issue_pc_1,
  output logic [XLEN-1:0]    issue_pc_2,
  output logic [RADDR_W-1:0] readaddr1_1,
  output logic [RADDR_W-1:0] readaddr2_1,
  output logic [RADDR_W-1:0] readaddr1_2,
  output logic [RADDR_W-1:0] readaddr2_2
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
  ,
  output logic [31:0]        split_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAIR  = 2'd1,
    SPLIT = 2'd2
  } state_t;

  state_t            state_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   instr0_r;
  logic [XLEN-1:0]   instr1_r;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [RADDR_W-1:0] dest0_s;
  logic [RADDR_W-1:0] dest1_s;
  logic              hazard_s;
  logic              accept_s;

  // Destination register; $0 is reported as "no destination" (zero).
  function automatic logic [RADDR_W-1:0] dest_of(input logic [5:0] op,
                                                 input logic [RADDR_W-1:0] rt,
                                                 input logic [RADDR_W-1:0] rd);
    logic [RADDR_W-1:0] d;
    case (op)
      6'h00:                                           d = rd;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: d = rt;
      default:                                         d = {RADDR_W{1'b0}};
    endcase
    return d;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    logic r;
    case (op)
      6'h00, 6'h04, 6'h05, 6'h2B: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  assign pc_plus4_s = pc_r + {{(XLEN-3){1'b0}}, 3'b100};
  assign dest0_s    = dest_of(instr0_r[31:26], instr0_r[20:16], instr0_r[15:11]);
  assign dest1_s    = dest_of(instr1_r[31:26], instr1_r[20:16], instr1_r[15:11]);
  assign accept_s   = in_valid & in_ready;

  // Intra-pair dependency check on the held pair.
  always_comb begin
    hazard_s = 1'b0;
    if (dest0_s != {RADDR_W{1'b0}}) begin
      hazard_s = (dest0_s == instr1_r[25:21])
               | (reads_rt(instr1_r[31:26]) & (dest0_s == instr1_r[20:16]))
               | (dest0_s == dest1_s);
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Lane contents and handshake; invalid lanes are driven to zero.
  always_comb begin
    in_ready      = 1'b0;
    issue_valid_1 = 1'b0;
    issue_valid_2 = 1'b0;
    issue_instr_1 = {XLEN{1'b0}};
    issue_instr_2 = {XLEN{1'b0}};
    issue_pc_1    = {XLEN{1'b0}};
    issue_pc_2    = {XLEN{1'b0}};
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      PAIR: begin
        issue_valid_1 = 1'b1;
        issue_instr_1 = instr0_r;
        issue_pc_1    = pc_r;
        in_ready      = out_ready & ~hazard_s;
        if (!hazard_s) begin
          issue_valid_2 = 1'b1;
          issue_instr_2 = instr1_r;
          issue_pc_2    = pc_plus4_s;
        end else begin
          issue_valid_2 = 1'b0;
        end
      end
      SPLIT: begin
        issue_valid_1 = 1'b1;
        issue_instr_1 = instr1_r;
        issue_pc_1    = pc_plus4_s;
        in_ready      = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign readaddr1_1 = issue_instr_1[25:21];
  assign readaddr2_1 = issue_instr_1[20:16];
  assign readaddr1_2 = issue_instr_2[25:21];
  assign readaddr2_2 = issue_instr_2[20:16];

  // Pair capture and issue sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= {XLEN{1'b0}};
      instr0_r <= {XLEN{1'b0}};
      instr1_r <= {XLEN{1'b0}};
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
      split_count <= 32'd0;
`endif
    end else begin
      if (accept_s) begin
        pc_r     <= in_pc;
        instr0_r <= in_instr0;
        instr1_r <= in_instr1;
      end
      case (state_r)
        IDLE:  if (in_valid) state_r <= PAIR;
        PAIR: begin
          if (out_ready) begin
            if (hazard_s) begin
              state_r <= SPLIT;
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
              split_count <= split_count + 32'd1;
`endif
            end else if (in_valid) begin
              state_r <= PAIR;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        SPLIT: if (out_ready) state_r <= in_valid ? PAIR : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_pair.sv
// Randomised and directed bench for issue_pair against a queue-of-issue-groups reference model.
module tb_issue_pair;
  logic        clk, rst, in_valid, in_ready, out_ready;
  logic [31:0] in_pc, in_instr0, in_instr1;
  logic        issue_valid_1, issue_valid_2;
  logic [31:0] issue_instr_1, issue_instr_2, issue_pc_1, issue_pc_2;
  logic [4:0]  readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2;
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
  logic [31:0] split_count;
`endif

  issue_pair dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .out_ready(out_ready),
    .issue_valid_1(issue_valid_1), .issue_valid_2(issue_valid_2),
    .issue_instr_1(issue_instr_1), .issue_instr_2(issue_instr_2),
    .issue_pc_1(issue_pc_1), .issue_pc_2(issue_pc_2),
    .readaddr1_1(readaddr1_1), .readaddr2_1(readaddr2_1),
    .readaddr1_2(readaddr1_2), .readaddr2_2(readaddr2_2)
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
    , .split_count(split_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each issue group is what one cycle of issue should present.
  typedef struct packed {
    logic        two;
    logic        last;
    logic [31:0] i1, p1, i2, p2;
  } grp_t;

  grp_t        q[$];
  logic [31:0] model_cnt;
  int          n_vec, n_bad;
  logic [150:0] dut_vec, exp_vec;

  assign dut_vec = {in_ready, issue_valid_1, issue_valid_2, issue_instr_1, issue_instr_2,
                    issue_pc_1, issue_pc_2, readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2};

  function automatic logic [4:0] m_dest(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'h00) return i[15:11];
    if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) return i[20:16];
    return 5'd0;
  endfunction

  function automatic logic m_hazard(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] d;
    logic       uses_rt;
    d = m_dest(a);
    uses_rt = b[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
    if (d == 5'd0) return 1'b0;
    return (d == b[25:21]) || (uses_rt && d == b[20:16]) || (d == m_dest(b));
  endfunction

  function automatic logic m_ready();
    if (q.size() == 0) return 1'b1;
    return out_ready && q[0].last;
  endfunction

  function automatic logic [150:0] m_expect();
    grp_t g;
    if (q.size() == 0) return {1'b1, 150'd0};
    g = q[0];
    return {m_ready(), 1'b1, g.two, g.i1, g.i2, g.p1, g.p2,
            g.i1[25:21], g.i1[20:16], g.i2[25:21], g.i2[20:16]};
  endfunction

  // Advance one clock: update model from the inputs seen at the edge.
  task automatic tick();
    logic rdy;
    grp_t g;
    rdy = m_ready();
    @(posedge clk);
    if (rst) begin
      q.delete();
      model_cnt = 32'd0;
    end else begin
      if (out_ready && q.size() > 0) begin
        if (!q[0].last) model_cnt = model_cnt + 32'd1;
        void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        if (m_hazard(in_instr0, in_instr1)) begin
          g = '{two: 1'b0, last: 1'b0, i1: in_instr0, p1: in_pc, i2: 32'd0, p2: 32'd0};
          q.push_back(g);
          g = '{two: 1'b0, last: 1'b1, i1: in_instr1, p1: in_pc + 32'd4, i2: 32'd0, p2: 32'd0};
          q.push_back(g);
        end else begin
          g = '{two: 1'b1, last: 1'b1, i1: in_instr0, p1: in_pc, i2: in_instr1, p2: in_pc + 32'd4};
          q.push_back(g);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ordy);
    in_valid = v; in_pc = pc; in_instr0 = i0; in_instr1 = i1; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== {1'b1, 150'd0}) begin
      n_bad++;
      $display("FAIL reset_state got=%h want=%h", dut_vec, {1'b1, 150'd0});
    end
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
    n_vec++;
    if (split_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_count got=%0d want=0", split_count);
    end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] i0s[3] = '{32'h00221820, 32'h00221820, 32'h00220020};
    logic [31:0] i1s[3] = '{32'h00C72020, 32'h20650001, 32'h20050001};
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 32'h100, i0s[t], i1s[t], 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      for (int c = 0; c < 3; c++) begin
        exp_vec = m_expect();
        n_vec++;
        if (dut_vec !== exp_vec) begin
          n_bad++;
          $display("FAIL directed%0d_c%0d got=%h want=%h", t, c, dut_vec, exp_vec);
        end
        tick();
      end
    end
    // Explicit spot values for the independent pair
    drive(1'b1, 32'h100, 32'h00221820, 32'h00C72020, 1'b1);
    tick();
    n_vec++;
    if ({issue_valid_1, issue_valid_2, issue_pc_1, issue_pc_2, readaddr1_1, readaddr2_1,
         readaddr1_2, readaddr2_2} !== {2'b11, 32'h100, 32'h104, 5'd1, 5'd2, 5'd6, 5'd7}) begin
      n_bad++;
      $display("FAIL indep_spot got=%b%b pc=%h/%h ra=%0d,%0d,%0d,%0d want=11 100/104 1,2,6,7",
               issue_valid_1, issue_valid_2, issue_pc_1, issue_pc_2,
               readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h200, 32'h00221820, 32'h00C72020, 1'b1);
    tick();
    drive(1'b1, 32'h300, 32'h00432020, 32'h00A63820, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (dut_vec !== {1'b0, 2'b11, 32'h00221820, 32'h00C72020, 32'h200, 32'h204,
                       5'd1, 5'd2, 5'd6, 5'd7}) begin
        n_bad++;
        $display("FAIL backpressure_hold_c%0d got=%h", c, dut_vec);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      exp_vec = m_expect();
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL backpressure_release_c%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, 32'h400 + 32'(c * 8), 32'h00221820 + 32'(c), 32'h00C72020, 1'b1);
      else       drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      exp_vec = m_expect();
      n_vec++;
      if (dut_vec !== exp_vec || (c >= 1 && c <= 4 && issue_valid_2 !== 1'b1)) begin
        n_bad++;
        $display("FAIL back_to_back_c%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_split();
    drive(1'b1, 32'h500, 32'h00221820, 32'h20650001, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    n_vec++;
    if ({issue_valid_1, issue_valid_2, issue_instr_1, issue_pc_1, readaddr1_1} !==
        {2'b10, 32'h20650001, 32'h504, 5'd3}) begin
      n_bad++;
      $display("FAIL split_lane got v=%b%b i=%h pc=%h ra=%0d want 10 20650001 504 3",
               issue_valid_1, issue_valid_2, issue_instr_1, issue_pc_1, readaddr1_1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== {1'b1, 150'd0}) begin
      n_bad++;
      $display("FAIL reset_in_split got=%h want=%h", dut_vec, {1'b1, 150'd0});
    end
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
    n_vec++;
    if (split_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_in_split_count got=%0d want=0", split_count);
    end
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[8] = '{6'h00, 6'h08, 6'h23, 6'h04, 6'h2B, 6'h02, 6'h0D, 6'h00};
    return {ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), 11'($urandom)};
  endfunction

  task automatic test_random();
    logic pending;
    pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(63) == 0);
      out_ready = ($urandom_range(3) != 0);
      if (!pending) begin
        in_valid = ($urandom_range(3) != 0);
        in_pc = (c % 50 == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
        in_instr0 = rand_instr();
        in_instr1 = rand_instr();
      end
      #1;
      exp_vec = m_expect();
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL random_c%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
`ifdef ISSUE_PAIR_SPLIT_CNT_EN
      n_vec++;
      if (split_count !== model_cnt) begin
        n_bad++;
        $display("FAIL random_count_c%0d got=%0d want=%0d", c, split_count, model_cnt);
      end
`endif
      pending = in_valid && !m_ready() && !rst;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; model_cnt = 32'd0;
    rst = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_instr0 = 32'd0; in_instr1 = 32'd0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_in_split();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
